// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the shared memory port (readM/writeM/address/data).
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module mem_port_arbiter #(
   parameter int unsigned WORD_SIZE   = 16,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req0,
   input  logic                 req1,
   input  logic                 we0,
   input  logic                 we1,
   input  logic [WORD_SIZE-1:0] addr0,
   input  logic [WORD_SIZE-1:0] addr1,
   input  logic [WORD_SIZE-1:0] wdata0,
   input  logic [WORD_SIZE-1:0] wdata1,
   output logic                 ack0,
   output logic                 ack1,
   output logic [WORD_SIZE-1:0] rdata,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] data,
   output logic                 busy
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   we_l_q, we_l_d;
   logic [WORD_SIZE-1:0]   addr_l_q, addr_l_d;
   logic [WORD_SIZE-1:0]   wdata_l_q, wdata_l_d;
   logic                   gnt_id_q, gnt_id_d;
   logic [WORD_SIZE-1:0]   rdata_q, rdata_d;
   logic                   ack0_q, ack0_d;
   logic                   ack1_q, ack1_d;
   logic                   read_m_q, read_m_d;
   logic                   write_m_q, write_m_d;
   logic [WORD_SIZE-1:0]   address_q, address_d;
   logic                   busy_q, busy_d;
   logic                   gnt_c;
   logic                   gnt_we_c;
   logic [WORD_SIZE-1:0]   gnt_addr_c;
   logic [WORD_SIZE-1:0]   gnt_wdata_c;
`ifdef ARB_ROUND_ROBIN_EN
   logic                   last_gnt_q, last_gnt_d;
`endif

   // Winner selection for a request sampled in IDLE
   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      if (req0 && req1) gnt_c = ~last_gnt_q;
      else              gnt_c = req1;
`else
      gnt_c = ~req0;
`endif
      gnt_we_c    = gnt_c ? we1    : we0;
      gnt_addr_c  = gnt_c ? addr1  : addr0;
      gnt_wdata_c = gnt_c ? wdata1 : wdata0;
   end

   // Next-state and registered-output decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_l_d    = we_l_q;
      addr_l_d  = addr_l_q;
      wdata_l_d = wdata_l_q;
      gnt_id_d  = gnt_id_q;
      rdata_d   = rdata_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      read_m_d  = 1'b0;
      write_m_d = 1'b0;
      address_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_d = last_gnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               gnt_id_d  = gnt_c;
               we_l_d    = gnt_we_c;
               addr_l_d  = gnt_addr_c;
               wdata_l_d = gnt_wdata_c;
               cnt_d     = CNT_W'(MEM_LATENCY - 1);
               read_m_d  = ~gnt_we_c;
               write_m_d = gnt_we_c;
               address_d = gnt_addr_c;
               state_d   = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
               last_gnt_d = gnt_c;
`endif
            end
         end
         ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d     = cnt_q - CNT_W'(1);
               read_m_d  = ~we_l_q;
               write_m_d = we_l_q;
               address_d = addr_l_q;
            end else begin
               if (!we_l_q) rdata_d = data;
               ack0_d  = ~gnt_id_q;
               ack1_d  = gnt_id_q;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         we_l_q    <= 1'b0;
         addr_l_q  <= '0;
         wdata_l_q <= '0;
         gnt_id_q  <= 1'b0;
         rdata_q   <= '0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         read_m_q  <= 1'b0;
         write_m_q <= 1'b0;
         address_q <= '0;
         busy_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_gnt_q <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_l_q    <= we_l_d;
         addr_l_q  <= addr_l_d;
         wdata_l_q <= wdata_l_d;
         gnt_id_q  <= gnt_id_d;
         rdata_q   <= rdata_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         read_m_q  <= read_m_d;
         write_m_q <= write_m_d;
         address_q <= address_d;
         busy_q    <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_gnt_q <= last_gnt_d;
`endif
      end
   end

   // Bus is only driven while the write strobe is up
   assign data    = write_m_q ? wdata_l_q : {WORD_SIZE{1'bz}};
   assign ack0    = ack0_q;
   assign ack1    = ack1_q;
   assign rdata   = rdata_q;
   assign readM   = read_m_q;
   assign writeM  = write_m_q;
   assign address = address_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboard of expected acks plus per-scenario cycle checks.
module tb_mem_port_arbiter;

   localparam int unsigned W = 16;
   localparam int unsigned L = 2;

   typedef struct {
      logic         id;
      logic         is_rd;
      logic [W-1:0] rd;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         req0, req1, we0, we1;
   logic [W-1:0] addr0, addr1, wdata0, wdata1;
   logic         ack0, ack1, readM, writeM, busy;
   logic [W-1:0] rdata, address;
   logic [W-1:0] rd_val;
   wire  [W-1:0] data;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   assign data = readM ? rd_val : {W{1'bz}};

   mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(L)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata),
      .readM(readM), .writeM(writeM), .address(address),
      .data(data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Scoreboard: every ack must match the oldest expected completion
   always @(negedge clk) begin
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
         checks++;
         if (ack0 === 1'b1 && ack1 === 1'b1) begin
            errors++;
            $display("FAIL sb_both_acks: ack0=%b ack1=%b, expected one-hot", ack0, ack1);
         end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_ack: ack0=%b ack1=%b with no pending access", ack0, ack1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (ack1 !== e.id || (e.is_rd && rdata !== e.rd)) begin
               errors++;
               $display("FAIL sb_ack: got id=%b rdata=%h, expected id=%b rdata=%h (read=%b)",
                        ack1, rdata, e.id, e.rd, e.is_rd);
            end
         end
      end
   end

   task automatic do_reset;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (ack0 !== 1'b0 || ack1 !== 1'b0 || readM !== 1'b0 || writeM !== 1'b0 ||
             address !== '0 || rdata !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals cycle %0d: ack0=%b ack1=%b readM=%b writeM=%b addr=%h rdata=%h busy=%b, expected all 0",
                     c, ack0, ack1, readM, writeM, address, rdata, busy);
         end
      end
      reset_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (readM !== 1'b0 || writeM !== 1'b0 || busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_vals cycle %0d: readM=%b writeM=%b busy=%b ack0=%b ack1=%b, expected 0",
                     c, readM, writeM, busy, ack0, ack1);
         end
      end
   endtask

   task automatic test_read;
      rd_val = 16'hBEEF;
      sb.push_back('{id: 1'b0, is_rd: 1'b1, rd: 16'hBEEF});
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
      for (int c = 1; c <= L; c++) begin
         @(negedge clk);
         checks++;
         if (readM !== 1'b1 || writeM !== 1'b0 || address !== 16'h0010 || busy !== 1'b1 || ack0 !== 1'b0) begin
            errors++;
            $display("FAIL read_access cycle %0d: readM=%b writeM=%b addr=%h busy=%b ack0=%b, expected 1 0 0010 1 0",
                     c, readM, writeM, address, busy, ack0);
         end
      end
      @(negedge clk);
      checks++;
      if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata !== 16'hBEEF || readM !== 1'b0) begin
         errors++;
         $display("FAIL read_resp: ack0=%b ack1=%b rdata=%h readM=%b, expected 1 0 beef 0",
                  ack0, ack1, rdata, readM);
      end
      req0 = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ack0 !== 1'b0 || rdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL read_after: busy=%b ack0=%b rdata=%h, expected 0 0 beef", busy, ack0, rdata);
      end
   endtask

   task automatic test_write;
      sb.push_back('{id: 1'b1, is_rd: 1'b0, rd: '0});
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'h1234;
      for (int c = 1; c <= L; c++) begin
         @(negedge clk);
         if (c == 1) wdata1 = 16'hFFFF;
         checks++;
         if (writeM !== 1'b1 || readM !== 1'b0 || address !== 16'h0020 || data !== 16'h1234) begin
            errors++;
            $display("FAIL write_access cycle %0d: writeM=%b readM=%b addr=%h data=%h, expected 1 0 0020 1234",
                     c, writeM, readM, address, data);
         end
      end
      @(negedge clk);
      checks++;
      if (ack1 !== 1'b1 || ack0 !== 1'b0 || writeM !== 1'b0 || rdata !== 16'hBEEF || data === 16'h1234) begin
         errors++;
         $display("FAIL write_resp: ack1=%b ack0=%b writeM=%b rdata=%h data=%h, expected 1 0 0 beef released",
                  ack1, ack0, writeM, rdata, data);
      end
      req1 = 1'b0;
      @(negedge clk);
      checks++;
      if (writeM !== 1'b0 || data === 16'h1234 || rdata !== 16'hBEEF || busy !== 1'b0) begin
         errors++;
         $display("FAIL write_after: writeM=%b data=%h rdata=%h busy=%b, expected 0 released beef 0",
                  writeM, data, rdata, busy);
      end
   endtask

   task automatic test_contention;
      int n = 0;
      int n1 = 0;
      do_reset();
      for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
         sb.push_back('{id: 1'(k % 2), is_rd: 1'b0, rd: '0});
`else
         sb.push_back('{id: 1'b0, is_rd: 1'b0, rd: '0});
`endif
      end
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0100; wdata0 = 16'hAAAA;
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0200; wdata1 = 16'h5555;
      for (int c = 0; c < 8 * (L + 2) && n < 4; c++) begin
         @(negedge clk);
         if (ack0 === 1'b1 || ack1 === 1'b1) begin
            n++;
            if (ack1 === 1'b1) n1++;
            if (n == 4) begin
               req0 = 1'b0;
               req1 = 1'b0;
            end
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL contention_count: got %0d acks, expected 4", n);
      end
      checks++;
`ifdef ARB_ROUND_ROBIN_EN
      if (n1 != 2) begin
`else
      if (n1 != 0) begin
`endif
         errors++;
         $display("FAIL contention_ack1: ack1 pulses=%0d, wrong for the arbitration mode", n1);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      rd_val = 16'h3333;
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0030;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (readM !== 1'b1 || address !== 16'h0030) begin
         errors++;
         $display("FAIL abort_setup: readM=%b addr=%h, expected 1 0030", readM, address);
      end
      reset_n = 1'b0;
      req0 = 1'b0;
      @(negedge clk);
      checks++;
      if (readM !== 1'b0 || writeM !== 1'b0 || ack0 !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort: readM=%b writeM=%b ack0=%b busy=%b, expected all 0", readM, writeM, ack0, busy);
      end
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rdata !== '0) begin
         errors++;
         $display("FAIL abort_idle: busy=%b rdata=%h, expected 0 0000", busy, rdata);
      end
      rd_val = 16'h7777;
      sb.push_back('{id: 1'b0, is_rd: 1'b1, rd: 16'h7777});
      req0 = 1'b1;
      for (int c = 0; c < L; c++) @(negedge clk);
      checks++;
      if (readM !== 1'b1 || address !== 16'h0030) begin
         errors++;
         $display("FAIL restart_access: readM=%b addr=%h, expected 1 0030", readM, address);
      end
      @(negedge clk);
      checks++;
      if (ack0 !== 1'b1 || rdata !== 16'h7777) begin
         errors++;
         $display("FAIL restart_resp: ack0=%b rdata=%h, expected 1 7777", ack0, rdata);
      end
      req0 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_drop;
      rd_val = 16'h5A5A;
      sb.push_back('{id: 1'b0, is_rd: 1'b1, rd: 16'h5A5A});
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
      @(negedge clk);
      req0 = 1'b0; addr0 = 16'h0099; we0 = 1'b1;
      for (int c = 2; c <= L; c++) begin
         @(negedge clk);
         checks++;
         if (readM !== 1'b1 || writeM !== 1'b0 || address !== 16'h0040) begin
            errors++;
            $display("FAIL drop_access cycle %0d: readM=%b writeM=%b addr=%h, expected 1 0 0040",
                     c, readM, writeM, address);
         end
      end
      @(negedge clk);
      checks++;
      if (ack0 !== 1'b1 || rdata !== 16'h5A5A) begin
         errors++;
         $display("FAIL drop_resp: ack0=%b rdata=%h, expected 1 5a5a", ack0, rdata);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ack0 !== 1'b0) begin
         errors++;
         $display("FAIL drop_after: busy=%b ack0=%b, expected 0 0", busy, ack0);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      rd_val = '0;
      @(negedge clk);
      test_reset();
      test_read();
      test_write();
      test_contention();
      test_reset_mid();
      test_drop();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d expected completions never acked, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
